joy_serial_reader: RTL and testbench



---
 rtl/joy_pkg.sv | 39 +++
 rtl/joy_clkdiv.sv | 45 ++++
 rtl/joy_serial_reader.sv | 153 +++++++++++++++
 tb/tb_joy_serial_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | joy_pkg : defaults, button bit positions and frame helpers for the reader |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package joy_pkg;

    localparam int DEF_NUM_PLAYERS     = 2;
    localparam int DEF_BITS_PER_PLAYER = 12;
    localparam int DEF_CLK_DIV         = 32;
    localparam int DEF_LEAD_BITS       = 2;
    localparam int DEF_DEBOUNCE_FRAMES = 2;

    // Bit positions inside one player's field (default 12-bit layout); bit 6 is unused.
    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_FIRE1 = 4;
    localparam int JOY_FIRE2 = 5;
    localparam int JOY_FIRE3 = 7;
    localparam int JOY_START = 8;
    localparam int JOY_COIN  = 9;
    localparam int JOY_EXTRA = 10;
    localparam int JOY_RESET = 11;

    typedef enum logic [1:0] {
        PH_LOAD = 2'd0,
        PH_LEAD = 2'd1,
        PH_DATA = 2'd2
    } slot_phase_e;

    function automatic int frame_len(input int lead_bits, input int num_players,
                                     input int bits_per_player);
        return lead_bits + num_players * bits_per_player;
    endfunction

endpackage
`default_nettype wire

// File: rtl/joy_clkdiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | joy_clkdiv : shifter clock divider with sample and slot-end ticks         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module joy_clkdiv #(
    parameter int CLK_DIV = 32
) (
    input  logic pclk_i,
    input  logic reset_i,
    output logic joy_clk_o,
    output logic sample_tick_o,
    output logic slot_tick_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] c_DIV_SMPL = DIV_W'(CLK_DIV / 2 - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             joy_clk_q;

    always_comb begin
        div_d = (div_q == c_DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    // joy_clk is derived from the next divider value so it tracks div_q exactly.
    always_ff @(posedge pclk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q     <= '0;
            joy_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            joy_clk_q <= (div_d >= c_DIV_HALF);
        end
    end

    assign joy_clk_o     = joy_clk_q;
    assign sample_tick_o = (div_q == c_DIV_SMPL);
    assign slot_tick_o   = (div_q == c_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/joy_serial_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | joy_serial_reader : 74HC165 chain reader with whole-frame debounce        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module joy_serial_reader
    import joy_pkg::*;
#(
    parameter int NUM_PLAYERS     = DEF_NUM_PLAYERS,
    parameter int BITS_PER_PLAYER = DEF_BITS_PER_PLAYER,
    parameter int CLK_DIV         = DEF_CLK_DIV,
    parameter int LEAD_BITS       = DEF_LEAD_BITS,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input  logic                                   pclk,
    input  logic                                   reset,
    input  logic                                   joy_data,
    output logic                                   joy_clk,
    output logic                                   joy_load,
    output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joy_state,
    output logic                                   frame_done,
    output logic                                   changed
);

    localparam int NB        = NUM_PLAYERS * BITS_PER_PLAYER;
    localparam int FRAME_LEN = frame_len(LEAD_BITS, NUM_PLAYERS, BITS_PER_PLAYER);
    localparam int SLOT_W    = $clog2(FRAME_LEN);

    localparam logic [SLOT_W-1:0] c_SLOT_LAST  = SLOT_W'(FRAME_LEN - 1);
    localparam logic [SLOT_W-1:0] c_LEAD       = SLOT_W'(LEAD_BITS);
    localparam logic [3:0]        c_STABLE_MAX = 4'(DEBOUNCE_FRAMES - 1);

    if (CLK_DIV < 4 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
        $error("joy_serial_reader: CLK_DIV must be even and at least 4");
    end
    if (LEAD_BITS < 1) begin : g_bad_lead_bits
        $error("joy_serial_reader: LEAD_BITS must be at least 1");
    end
    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
        $error("joy_serial_reader: DEBOUNCE_FRAMES must be in 1..15");
    end
    if (NUM_PLAYERS < 1 || BITS_PER_PLAYER < 1) begin : g_bad_layout
        $error("joy_serial_reader: NUM_PLAYERS and BITS_PER_PLAYER must be at least 1");
    end

    logic              w_sample_tick;
    logic              w_slot_tick;

    joy_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .pclk_i        (pclk),
        .reset_i       (reset),
        .joy_clk_o     (joy_clk),
        .sample_tick_o (w_sample_tick),
        .slot_tick_o   (w_slot_tick)
    );

    logic [1:0]        sync_q;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;
    logic              load_q;
    logic [NB-1:0]     raw_q;
    logic [NB-1:0]     raw_d;
    logic [NB-1:0]     last_raw_q;
    logic [NB-1:0]     last_raw_d;
    logic [3:0]        stable_q;
    logic [3:0]        stable_d;
    logic [NB-1:0]     state_q;
    logic [NB-1:0]     state_d;
    logic              frame_done_q;
    logic              changed_q;

    slot_phase_e       w_phase;
    logic              w_capture;
    logic              w_eof;
    logic              w_publish;

    always_comb begin
        if (slot_q == '0) begin
            w_phase = PH_LOAD;
        end else if (slot_q < c_LEAD) begin
            w_phase = PH_LEAD;
        end else begin
            w_phase = PH_DATA;
        end
    end

    assign w_capture = w_sample_tick && (w_phase == PH_DATA);
    assign w_eof     = w_sample_tick && (slot_q == c_SLOT_LAST);

    always_comb begin
        slot_d = slot_q;
        if (w_slot_tick) begin
            slot_d = (slot_q == c_SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
        end
    end

    // Shifting MSB-first leaves data slot k at raw[NB-1-k] once the frame is complete.
    always_comb begin
        raw_d      = raw_q;
        last_raw_d = last_raw_q;
        stable_d   = stable_q;
        state_d    = state_q;
        w_publish  = 1'b0;
        if (w_capture) begin
            raw_d = NB'({raw_q, sync_q[1]});
        end
        if (w_eof) begin
            if (raw_d == last_raw_q) begin
                stable_d = (stable_q == c_STABLE_MAX) ? stable_q : stable_q + 4'd1;
            end else begin
                stable_d = '0;
            end
            last_raw_d = raw_d;
            if (stable_d == c_STABLE_MAX) begin
                w_publish = 1'b1;
                state_d   = raw_d;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            sync_q       <= 2'b11;
            slot_q       <= '0;
            load_q       <= 1'b1;
            raw_q        <= '1;
            last_raw_q   <= '1;
            stable_q     <= '0;
            state_q      <= '1;
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], joy_data};
            slot_q       <= slot_d;
            load_q       <= (slot_d != '0);
            raw_q        <= raw_d;
            last_raw_q   <= last_raw_d;
            stable_q     <= stable_d;
            state_q      <= state_d;
            frame_done_q <= w_eof;
            changed_q    <= w_publish && (raw_d != state_q);
        end
    end

    assign joy_load   = load_q;
    assign joy_state  = state_q;
    assign frame_done = frame_done_q;
    assign changed    = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_joy_serial_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_joy_serial_reader : vector table + scoreboard bench for the reader     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_joy_serial_reader;

    localparam int CD       = 32;
    localparam int HALF     = CD / 2;
    localparam int FL       = 26;
    localparam int NB       = 24;
    localparam int PERIOD   = FL * CD;
    localparam int CD_B     = 8;
    localparam int FL_B     = 34;
    localparam int PERIOD_B = FL_B * CD_B;

    typedef struct packed {
        logic [23:0] state;
        logic        chg;
    } exp_t;

    typedef struct {
        logic [23:0] pat;
        logic [23:0] st;
        logic        chg;
    } vec_t;

    logic        pclk   = 1'b0;
    logic        reset  = 1'b1;
    logic        a_data = 1'b1;
    logic        a_clk, a_load, a_fd, a_chg;
    logic [23:0] a_state;
    logic        b_data;
    logic        b_clk, b_load, b_fd, b_chg;
    logic [31:0] b_state;
    logic [31:0] pat_b = 32'h80FF00A5;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];

    logic [23:0] m_last   = 24'hFFFFFF;
    logic [23:0] m_state  = 24'hFFFFFF;
    int          m_stable = 0;

    always #5 pclk = ~pclk;

    joy_serial_reader u_dut_a (
        .pclk       (pclk),
        .reset      (reset),
        .joy_data   (a_data),
        .joy_clk    (a_clk),
        .joy_load   (a_load),
        .joy_state  (a_state),
        .frame_done (a_fd),
        .changed    (a_chg)
    );

    joy_serial_reader #(
        .NUM_PLAYERS     (4),
        .BITS_PER_PLAYER (8),
        .CLK_DIV         (CD_B),
        .LEAD_BITS       (2),
        .DEBOUNCE_FRAMES (1)
    ) u_dut_b (
        .pclk       (pclk),
        .reset      (reset),
        .joy_data   (b_data),
        .joy_clk    (b_clk),
        .joy_load   (b_load),
        .joy_state  (b_state),
        .frame_done (b_fd),
        .changed    (b_chg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Reference debounce for DEBOUNCE_FRAMES = 2.
    task automatic model_step(input logic [23:0] pat, output exp_t e);
        if (pat == m_last) begin
            if (m_stable < 1) m_stable++;
        end else begin
            m_stable = 0;
        end
        m_last = pat;
        e.chg  = 1'b0;
        if (m_stable == 1) begin
            e.chg   = (pat != m_state);
            m_state = pat;
        end
        e.state = m_state;
    endtask

    task automatic model_reset();
        m_last   = 24'hFFFFFF;
        m_state  = 24'hFFFFFF;
        m_stable = 0;
    endtask

    // Called when the DUT sits at slot 0 / div 0; drives one full frame of chain data.
    task automatic drive_frame(input logic [23:0] pat, input exp_t e, input int tog_div,
                               input int abort_slot);
        for (int s = 0; s < FL; s++) begin
            logic bitv;
            bitv   = (s >= 2) ? pat[NB-1-(s-2)] : 1'b1;
            a_data = bitv;
            if (s == FL - 1) sb_q.push_back(e);
            for (int d = 0; d < CD; d++) begin
                if (s == 2 && d == tog_div) a_data = ~bitv;
                if (s == abort_slot && d == 5) begin
                    reset = 1'b1;
                    return;
                end
                @(posedge pclk);
                #1;
            end
        end
    endtask

    // Monitor for instance A: scoreboard pop, frame period, load and clock duty.
    int   a_cyc, a_low, a_high;
    bit   a_seen;
    exp_t a_e;
    always @(negedge pclk) begin
        if (reset) begin
            a_seen = 0; a_cyc = 0; a_low = 0; a_high = 0;
        end else begin
            a_cyc++;
            if (!a_load) a_low++;
            if (a_clk) a_high++;
            if (a_fd) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_frame_done: got frame_done=1, required no frame end");
                end else begin
                    a_e = sb_q.pop_front();
                    check("joy_state", {8'h0, a_state}, {8'h0, a_e.state});
                    check("changed", {31'h0, a_chg}, {31'h0, a_e.chg});
                end
                if (a_seen) begin
                    check("frame_period", a_cyc, PERIOD);
                    check("load_low_cycles", a_low, CD);
                    check("clk_high_cycles", a_high, FL * HALF);
                end
                a_seen = 1; a_cyc = 0; a_low = 0; a_high = 0;
            end else if (a_chg) begin
                check("changed_without_frame_done", {31'h0, a_chg}, 32'h0);
            end
        end
    end

    // Chain model for instance B: bench-side slot timing, fixed pattern every frame.
    int bd, bs;
    always @(posedge pclk or posedge reset) begin
        if (reset) begin
            bd <= 0;
            bs <= 0;
        end else if (bd == CD_B - 1) begin
            bd <= 0;
            bs <= (bs == FL_B - 1) ? 0 : bs + 1;
        end else begin
            bd <= bd + 1;
        end
    end
    always_comb b_data = (bs >= 2) ? pat_b[33-bs] : 1'b1;

    int b_cyc, b_nfd;
    bit b_seen, b_first;
    always @(negedge pclk) begin
        if (reset) begin
            b_seen = 0; b_first = 1; b_cyc = 0;
        end else begin
            b_cyc++;
            if (b_fd) begin
                b_nfd++;
                check("b_joy_state", b_state, 32'h80FF00A5);
                check("b_player0_byte", {24'h0, b_state[7:0]}, 32'hA5);
                check("b_player3_byte", {24'h0, b_state[31:24]}, 32'h80);
                check("b_changed", {31'h0, b_chg}, {31'h0, b_first});
                if (b_seen) check("b_frame_period", b_cyc, PERIOD_B);
                b_seen = 1; b_first = 0; b_cyc = 0;
            end else if (b_chg) begin
                check("b_changed_without_frame_done", {31'h0, b_chg}, 32'h0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    vec_t        tbl[12];
    exp_t        e;
    logic [23:0] pool[3];
    logic [23:0] pat;

    initial begin
        tbl[0]  = '{24'hFFFFFE, 24'hFFFFFF, 1'b0};
        tbl[1]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0};
        tbl[2]  = '{24'hFFFFFE, 24'hFFFFFF, 1'b0};
        tbl[3]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0};
        tbl[4]  = '{24'hFFFFFE, 24'hFFFFFF, 1'b0};
        tbl[5]  = '{24'hFFFFFE, 24'hFFFFFE, 1'b1};
        tbl[6]  = '{24'hFFFFFE, 24'hFFFFFE, 1'b0};
        tbl[7]  = '{24'h7FFFFF, 24'hFFFFFE, 1'b0};
        tbl[8]  = '{24'h7FFFFF, 24'h7FFFFF, 1'b1};
        tbl[9]  = '{24'hA5A5A5, 24'h7FFFFF, 1'b0};
        tbl[10] = '{24'h7FFFFF, 24'h7FFFFF, 1'b0};
        tbl[11] = '{24'h7FFFFF, 24'h7FFFFF, 1'b0};

        repeat (4) @(posedge pclk);
        #1;
        check("rst_joy_clk", {31'h0, a_clk}, 32'h0);
        check("rst_joy_load", {31'h0, a_load}, 32'h1);
        check("rst_joy_state", {8'h0, a_state}, 32'h00FFFFFF);
        check("rst_frame_done", {31'h0, a_fd}, 32'h0);
        check("rst_changed", {31'h0, a_chg}, 32'h0);
        check("rst_b_joy_state", b_state, 32'hFFFFFFFF);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            model_step(tbl[i].pat, e);
            e.state = tbl[i].st;
            e.chg   = tbl[i].chg;
            drive_frame(tbl[i].pat, e, -1, -1);
        end

        // Reset mid-frame while a pressed bit 23 is being shifted in.
        e = '{state: 24'h7FFFFF, chg: 1'b0};
        drive_frame(24'h7FFFFF, e, -1, 15);
        #1;
        check("async_reset_state", {8'h0, a_state}, 32'h00FFFFFF);
        check("async_reset_frame_done", {31'h0, a_fd}, 32'h0);
        sb_q.delete();
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check("no_load_in_reset", {31'h0, a_load}, 32'h1);
        reset = 1'b0;
        #1;
        check("load_high_at_release", {31'h0, a_load}, 32'h1);
        #3;
        model_step(24'h7FFFFF, e);
        fork
            drive_frame(24'h7FFFFF, e, -1, -1);
            begin
                @(posedge pclk);
                #1;
                check("load_low_first_edge", {31'h0, a_load}, 32'h0);
            end
        join
        model_step(24'h7FFFFF, e);
        drive_frame(24'h7FFFFF, e, -1, -1);

        // Toggle 1 cycle before the sample: old value (1) captured.
        for (int i = 0; i < 2; i++) begin
            model_step(24'hFFFFFF, e);
            drive_frame(24'hFFFFFF, e, HALF - 1, -1);
        end
        // Toggle 3 cycles before the sample: new value (0) captured.
        for (int i = 0; i < 2; i++) begin
            model_step(24'h7FFFFF, e);
            drive_frame(24'hFFFFFF, e, HALF - 3, -1);
        end

        pool[0] = 24'($urandom);
        pool[1] = 24'($urandom);
        pool[2] = 24'hFFFFFF;
        pat     = pool[0];
        for (int i = 0; i < 40; i++) begin
            if (i == 20) pool[1] = 24'($urandom);
            if ($urandom_range(0, 1) == 0) pat = pool[$urandom_range(0, 2)];
            model_step(pat, e);
            drive_frame(pat, e, -1, -1);
        end

        repeat (10) @(posedge pclk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        check("b_frames_seen", {31'h0, (b_nfd >= 100)}, 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
